// File: rtl/sap_cpu_pkg.sv
// Shared definitions for the SAP CPU core: default sizes, opcode
// encodings and the control state type.
package sap_cpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/sap_cpu_core_alu.sv
// Combinational add/subtract unit with carry and zero flags.
// For subtraction the carry flag means "no borrow" (a >= b).
module sap_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              cf,
    output logic              zf
);

    logic [DATA_W:0] sum;

    // Result and flags for the selected operation.
    always_comb begin
        sum = '0;
        if (sub) begin
            result = a - b;
            cf     = (a >= b);
        end else begin
            sum    = {1'b0, a} + {1'b0, b};
            result = sum[DATA_W-1:0];
            cf     = sum[DATA_W];
        end
        zf = (result == '0);
    end

endmodule

// File: rtl/sap_cpu_core.sv
// SAP-style accumulator CPU with a program-load port.
// Optional feature macro: SAP_CPU_COND_JUMP_EN enables the JC/JZ
// conditional jumps; without it opcodes 7 and 8 execute as NOP.
//
// Load handshake: a word on prog_data is taken on a rising edge where
// prog_valid and prog_ready are both 1; prog_valid may be held high and
// prog_data must stay stable until that edge. prog_ready is 1 only in
// LOAD while the memory image is not yet complete.
module sap_cpu_core
    import sap_cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_en,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              load_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output state_t            dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] load_ptr;
    // Only the opcode and operand fields of the fetched word are kept;
    // the middle bits of an instruction carry no meaning.
    logic [3:0]        ir_op;
    logic [ADDR_W-1:0] ir_k;
    logic [DATA_W-1:0] acc;
    logic              cf;
    logic              zf;

    logic [DATA_W-1:0] mem_k;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cf;
    logic              alu_zf;
    logic              take_jc;
    logic              take_jz;

    assign mem_k      = mem[ir_k];
    assign prog_ready = (state == ST_LOAD) && !load_done;
    assign halted     = (state == ST_HALT);
    assign dbg_state  = state;

`ifdef SAP_CPU_COND_JUMP_EN
    assign take_jc = (ir_op == OP_JC) && cf;
    assign take_jz = (ir_op == OP_JZ) && zf;
`else
    assign take_jc = 1'b0;
    assign take_jz = 1'b0;
`endif

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (acc),
        .b      (mem_k),
        .sub    (ir_op == OP_SUB),
        .result (alu_res),
        .cf     (alu_cf),
        .zf     (alu_zf)
    );

    // Control FSM together with all architectural state and memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= '0;
            load_ptr  <= '0;
            ir_op     <= '0;
            ir_k      <= '0;
            acc       <= '0;
            cf        <= 1'b0;
            zf        <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            load_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pc    <= '0;
                    state <= prog_en ? ST_LOAD : ST_FETCH;
                end
                ST_LOAD: begin
                    if (!prog_en) begin
                        pc    <= '0;
                        state <= ST_FETCH;
                    end else if (prog_valid && prog_ready) begin
                        mem[load_ptr] <= prog_data;
                        load_ptr      <= load_ptr + 1'b1;
                        if (&load_ptr) begin
                            load_done <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    ir_op <= mem[pc][DATA_W-1 -: 4];
                    ir_k  <= mem[pc][ADDR_W-1:0];
                    pc    <= pc + 1'b1;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    case (ir_op)
                        OP_LDA: acc <= mem_k;
                        OP_ADD, OP_SUB: begin
                            acc <= alu_res;
                            cf  <= alu_cf;
                            zf  <= alu_zf;
                        end
                        OP_STA: mem[ir_k] <= acc;
                        OP_LDI: acc <= {{(DATA_W-ADDR_W){1'b0}}, ir_k};
                        OP_JMP: pc <= ir_k;
                        OP_JC, OP_JZ: begin
                            if (take_jc || take_jz) begin
                                pc <= ir_k;
                            end
                        end
                        OP_OUT: begin
                            out_data  <= acc;
                            out_valid <= 1'b1;
                        end
                        OP_HLT: state <= ST_HALT;
                        default: ;
                    endcase
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
